pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised, handshaked pipeline stage register that replaces the fixed ID/EXE, EXE/MEM and MEM/WB latch bundles. It is a DEPTH-entry circular buffer carrying an opaque DATA_W payload plus an EXC_W exception vector between two adjacent pipeline stages. It has valid/ready flow control, whole-stage flush, and a precise-exception hold: once an excepting instruction is accepted, younger instructions are blocked until flush.

## Interface
- DATA_W, 32, payload width in bits (1..256); packed stage fields are concatenated by the instantiating stage.
- EXC_W, 6, exception vector width (ExceptinPipeType is 6 bits).
- DEPTH, 2, number of entries (1..8); need not be a power of two.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  buffer can accept an entry.
- in_data  in  DATA_W  upstream payload.
- in_exc  in  EXC_W  upstream exception bits.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes the head.
- out_data  out  DATA_W  head payload.
- out_exc  out  EXC_W  head exception bits.
- exc_pending  out  1  an excepting entry has been accepted and no flush has occurred since.
- count  out  CNT_W  current occupancy.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- State registers: mem[DEPTH] of {in_data, in_exc}, wr_ptr, rd_ptr, count, exc_hold.
- On push, the entry is written at wr_ptr. wr_ptr advances, wrapping from DEPTH-1 to 0.
- On pop, rd_ptr advances with the same wrap rule.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_valid = (count != 0). out_data/out_exc = mem[rd_ptr].
- out_data/out_exc are unspecified while out_valid=0; the bench must not check them then.
- in_ready = !rst & (count < DEPTH) & !exc_hold.
  - in_ready is a function of registers only; there is no combinational path from out_ready.
  - When full, a same-cycle pop does not enable a push.
- exc_hold: set on a push whose in_exc != 0; cleared only by rst or flush. exc_pending = exc_hold.
- While exc_hold=1, already-buffered entries, including the excepting one, keep draining normally.
- flush: next cycle count=0, wr_ptr=rd_ptr=0, exc_hold=0.
  - A push or pop in the flush cycle is discarded and has no effect.
  - Flush has priority over push/pop.
- rst: same effect as flush. Priority is rst > flush > push/pop. mem contents are not reset.
- Reset values, in the cycle after rst is sampled: out_valid=0, count=0, exc_pending=0, in_ready=1.
  - in_ready is 0 while rst is high.
- Illegal stimulus: in_valid dropping, or in_data changing, while in_ready=0 is legal. The upstream is not required to hold its offer.

## Timing
- Latency: an entry pushed at edge N is presented at out_* after edge N (cycle N+1). Minimum latency is one cycle, with no bypass.
- Throughput: one entry per cycle when DEPTH >= 2 and the downstream is ready.
- With DEPTH=1, throughput is one entry per 2 cycles, because there is no pop-enables-push path.
- Empty plus push: out_valid rises the next cycle. A same-cycle out_ready has no effect.
- Full plus pop: in_ready rises the next cycle.
- Wrap: the pointer at DEPTH-1 goes to 0 on the next advance. No aliasing, because count, not pointer compare, tracks occupancy.
- Mid-operation reset or flush with a partially filled buffer: all entries are lost, and out_valid=0 the next cycle.

## Test plan
- Reset/fill/drain (DEPTH=3): push 0xA1, 0xA2, 0xA3 with out_ready=0. Required: count=3, in_ready=0. Then raise out_ready. Required: outputs A1, A2, A3 on consecutive cycles, then out_valid=0 and count=0.
- Streaming and wrap (DEPTH=3): 10 back-to-back pushes 0..9 with out_ready=1. Required: out_data 0..9 in order with one-cycle latency, count steady at 1, and pointers wrapping cleanly.
- Simultaneous push/pop on a full buffer (DEPTH=2): full, with in_valid=1 and out_ready=1. Required: pop occurs, push is refused that cycle, count=1, and in_ready=1 the next cycle.
- Exception hold: push 0x10 (exc=0), 0x11 (exc=6'b000100), 0x12 (exc=0). Required: 0x12 is refused, with in_ready=0 and exc_pending=1. 0x10 and 0x11 drain, with out_exc=6'b000100 on 0x11. in_ready stays 0 until flush.
- Flush with push: buffer holds 2 entries; assert flush with in_valid=1 and data 0x55. Required next cycle: count=0, out_valid=0, exc_pending=0, and 0x55 never appears.
- Reset mid-stream plus DEPTH=1: rst during traffic gives in_ready=0 while rst is high, and out_valid=0 and count=0 after. With DEPTH=1 streaming, an accepted entry appears on alternate cycles only.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Handshaked pipeline stage register built as a DEPTH-entry circular buffer.
// It carries an opaque DATA_W payload plus an EXC_W exception vector between
// two adjacent pipeline stages.
//
// Once an entry with a non-zero exception vector is accepted, no younger entry
// is accepted until flush or reset. This keeps exceptions precise. Entries
// that are already buffered, including the excepting one, keep draining.
//
// Parameters:
//   DATA_W  payload width in bits (1..256)
//   EXC_W   exception vector width
//   DEPTH   number of entries (1..8); need not be a power of two
//   CNT_W   occupancy counter width (derived; do not override)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (priority over flush)
//   flush        synchronous discard of all entries (priority over push/pop)
//   in_valid     upstream offers an entry
//   in_ready     buffer accepts an entry; depends only on rst and registers
//   in_data      upstream payload
//   in_exc       upstream exception bits
//   out_valid    head entry present
//   out_ready    downstream consumes the head
//   out_data     head payload (undefined while out_valid=0)
//   out_exc      head exception bits (undefined while out_valid=0)
//   exc_pending  an excepting entry was accepted since the last flush/reset
//   count        current occupancy
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 6,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              exc_pending,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = DATA_W + EXC_W;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             exc_hold;

  logic push;
  logic pop;
  logic discard;

  // Pointers wrap explicitly at DEPTH-1 so that non-power-of-two depths work.
  // Occupancy comes from cnt_q, not from comparing the pointers, so a full
  // buffer is never mistaken for an empty one.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Reset and flush have the same effect: every handshake in that cycle is
  // dropped.
  assign discard = rst | flush;

  // in_ready does not look at out_ready. A full buffer therefore refuses a
  // push even when the head leaves in the same cycle. This keeps the ready
  // path between stages free of a combinational chain.
  assign in_ready = !rst && (cnt_q < FULL_CNT) && !exc_hold;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign out_valid   = (cnt_q != '0);
  assign out_data    = mem[rd_ptr][ENT_W-1:EXC_W];
  assign out_exc     = mem[rd_ptr][EXC_W-1:0];
  assign exc_pending = exc_hold;
  assign count       = cnt_q;

  // NOTE: sequential state is assigned with non-blocking (<=) so that every
  // register samples the pre-edge values of the others. Blocking assignments
  // here would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (discard) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      exc_hold <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);

      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      // The hold bit is sticky. Only the discard branch above clears it.
      if (push && (in_exc != '0)) exc_hold <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset. An entry is only ever read after a
  // push has written it, because cnt_q gates out_valid. Keeping reset off the
  // array lets it map onto plain registers or LUT RAM without a clear network.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {in_data, in_exc};
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Three instances (DEPTH = 1, 2, 3) run side by side. Each instance has its own
// reference model. The model is a queue of the entries still owed downstream
// plus a sticky exception flag.
//
// Every cycle, on the falling edge, the monitor compares the outputs against
// the model: in_ready, out_valid, count, exc_pending, and the head entry while
// one is owed. It then applies that cycle's handshakes to the model. Entries
// are pushed into the scoreboard when the stimulus is accepted. They are popped
// when the DUT presents them and the downstream takes them.
//
// Directed sequences come first, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam int DW   = 32;
  localparam int EW   = 6;
  localparam int NDUT = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] exc;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [NDUT];
  logic          flush     [NDUT];
  logic          in_valid  [NDUT];
  logic          in_ready  [NDUT];
  logic [DW-1:0] in_data   [NDUT];
  logic [EW-1:0] in_exc    [NDUT];
  logic          out_valid [NDUT];
  logic          out_ready [NDUT];
  logic [DW-1:0] out_data  [NDUT];
  logic [EW-1:0] out_exc   [NDUT];
  logic          exc_pend  [NDUT];
  logic [3:0]    count     [NDUT];

  int errors = 0;
  int checks = 0;
  bit run_checks = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int D  = g + 1;
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] cnt_l;

    pipe_stage_buf #(.DATA_W(DW), .EXC_W(EW), .DEPTH(D)) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .flush      (flush[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .in_exc     (in_exc[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .out_exc    (out_exc[g]),
      .exc_pending(exc_pend[g]),
      .count      (cnt_l)
    );
    assign count[g] = 4'(cnt_l);

    // Reference model: the entries owed downstream, in order, plus a hold flag.
    ent_t sb[$];
    bit   hold = 1'b0;

    always @(negedge clk) begin
      bit   exp_ready;
      bit   exp_valid;
      bit   do_push;
      bit   do_pop;
      ent_t head;
      exp_ready = !rst[g] && (sb.size() < D) && !hold;
      exp_valid = (sb.size() != 0);
      if (run_checks) begin
        check($sformatf("d%0d in_ready", D), 64'(in_ready[g]), 64'(exp_ready));
        check($sformatf("d%0d out_valid", D), 64'(out_valid[g]), 64'(exp_valid));
        check($sformatf("d%0d count", D), 64'(count[g]), 64'(sb.size()));
        check($sformatf("d%0d exc_pending", D), 64'(exc_pend[g]), 64'(hold));
        if (exp_valid) begin
          head = sb[0];
          check($sformatf("d%0d out_data", D), 64'(out_data[g]), 64'(head.data));
          check($sformatf("d%0d out_exc", D), 64'(out_exc[g]), 64'(head.exc));
        end
      end
      do_pop  = exp_valid && out_ready[g];
      do_push = in_valid[g] && exp_ready;
      if (rst[g] || flush[g]) begin
        sb.delete();
        hold = 1'b0;
      end else begin
        if (do_pop) void'(sb.pop_front());
        if (do_push) begin
          sb.push_back(ent_t'{data: in_data[g], exc: in_exc[g]});
          if (in_exc[g] != '0) hold = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    in_valid[k]  = 1'b0;
    in_data[k]   = '0;
    in_exc[k]    = '0;
    out_ready[k] = 1'b0;
    flush[k]     = 1'b0;
    rst[k]       = 1'b0;
  endtask

  task automatic offer(input int k, input logic [DW-1:0] d, input logic [EW-1:0] e);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_exc[k]   = e;
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      idle(k);
      rst[k] = 1'b1;
    end
    step();
    run_checks = 1'b1;
    step();
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
    step();

    // Fill then drain, DEPTH=3.
    for (int i = 0; i < 3; i++) begin
      offer(2, DW'(32'hA1 + i), '0);
      step();
    end
    in_valid[2] = 1'b0;
    @(negedge clk);
    check("fill count", 64'(count[2]), 64'(3));
    check("fill in_ready", 64'(in_ready[2]), 64'(0));
    step();
    out_ready[2] = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("drain out_valid", 64'(out_valid[2]), 64'(0));
    check("drain count", 64'(count[2]), 64'(0));
    step();

    // Streaming with pointer wrap, DEPTH=3.
    for (int i = 0; i < 10; i++) begin
      offer(2, DW'(i), '0);
      if (i > 0) begin
        @(negedge clk);
        check("stream count", 64'(count[2]), 64'(1));
      end
      step();
    end
    in_valid[2] = 1'b0;
    step();
    idle(2);

    // Full plus simultaneous push/pop, DEPTH=2.
    offer(1, 32'hC1, '0); step();
    offer(1, 32'hC2, '0); step();
    offer(1, 32'hC3, '0);
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("full pop in_ready", 64'(in_ready[1]), 64'(0));
    step();
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    @(negedge clk);
    check("after pop count", 64'(count[1]), 64'(1));
    check("after pop in_ready", 64'(in_ready[1]), 64'(1));
    out_ready[1] = 1'b1;
    step(); step();
    idle(1);

    // Exception hold, DEPTH=3.
    offer(2, 32'h10, '0);        step();
    offer(2, 32'h11, 6'b000100); step();
    offer(2, 32'h12, '0);
    @(negedge clk);
    check("exc in_ready", 64'(in_ready[2]), 64'(0));
    check("exc pending", 64'(exc_pend[2]), 64'(1));
    out_ready[2] = 1'b1;
    step();
    @(negedge clk);
    check("exc head exc", 64'(out_exc[2]), 64'(6'b000100));
    step();
    @(negedge clk);
    check("exc drained valid", 64'(out_valid[2]), 64'(0));
    check("exc held in_ready", 64'(in_ready[2]), 64'(0));
    flush[2] = 1'b1;
    step();
    idle(2);
    @(negedge clk);
    check("exc flushed pending", 64'(exc_pend[2]), 64'(0));
    check("exc flushed in_ready", 64'(in_ready[2]), 64'(1));
    step();

    // Flush with a same-cycle push, DEPTH=3.
    offer(2, 32'h20, '0); step();
    offer(2, 32'h21, '0); step();
    offer(2, 32'h55, '0);
    flush[2] = 1'b1;
    step();
    idle(2);
    @(negedge clk);
    check("flush count", 64'(count[2]), 64'(0));
    check("flush out_valid", 64'(out_valid[2]), 64'(0));
    check("flush pending", 64'(exc_pend[2]), 64'(0));
    step();

    // Reset mid-stream, DEPTH=3.
    offer(2, 32'h30, '0); step();
    offer(2, 32'h31, '0); step();
    offer(2, 32'h32, '0);
    rst[2] = 1'b1;
    @(negedge clk);
    check("rst in_ready", 64'(in_ready[2]), 64'(0));
    step();
    idle(2);
    @(negedge clk);
    check("rst out_valid", 64'(out_valid[2]), 64'(0));
    check("rst count", 64'(count[2]), 64'(0));
    step();

    // DEPTH=1 streaming: accepts on alternate cycles only.
    out_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(0, DW'(32'h40 + i), '0);
      @(negedge clk);
      check("d1 alternate in_ready", 64'(in_ready[0]), 64'((i % 2) == 0));
      step();
    end
    in_valid[0] = 1'b0;
    step();
    idle(0);

    // Randomized traffic on all three instances.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NDUT; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_data[k]   = $urandom;
        in_exc[k]    = ($urandom_range(0, 31) == 0) ? EW'($urandom_range(1, 63)) : '0;
        out_ready[k] = ($urandom_range(0, 2) != 0);
        flush[k]     = ($urandom_range(0, 24) == 0);
        rst[k]       = ($urandom_range(0, 199) == 0);
      end
      step();
    end
    for (int k = 0; k < NDUT; k++) begin
      idle(k);
      out_ready[k] = 1'b1;
    end
    repeat (5) step();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check("final empty", 64'(out_valid[k]), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
